pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush performance counters.
REQ-002 Parameter: MD_TIMEOUT, 63, maximum number of MD_WAIT cycles before a forced release.
REQ-003 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: load_use_stall  in  1  load-use hazard flag from the bypass/hazard unit (lw in DX, dependent instruction in FD).
REQ-006 Port: branch_taken_dx  in  1  DX instruction redirects the PC (taken blt/bne, j, jal, jr, bex).
REQ-007 Port: md_op_dx  in  1  DX instruction is mul or div.
REQ-008 Port: md_ready  in  1  multdiv result valid (one-cycle pulse).
REQ-009 Port: md_exception  in  1  multdiv overflow or divide-by-zero, valid with md_ready.
REQ-010 Port: pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each  latch write enables.
REQ-011 Port: fd_flush  out  1  load nop into the FD latch.
REQ-012 Port: dx_bubble  out  1  load nop into the DX latch.
REQ-013 Port: xm_bubble  out  1  load nop into the XM latch.
REQ-014 Port: md_start  out  1  one-cycle start pulse to multdiv.
REQ-015 Port: md_busy  out  1  high while in MD_WAIT.
REQ-016 Port: md_timeout  out  1  sticky timeout flag; cleared only by reset.
REQ-017 Port: stall_count, flush_count  out  CNT_W each  saturating performance counters.

Function
REQ-018 The FSM SHALL have exactly two states: RUN and MD_WAIT.
REQ-019 In RUN, branch_taken_dx SHALL have the highest priority: fd_flush=1, dx_bubble=1, all enables=1, next state RUN; load_use_stall and md_op_dx are ignored that cycle.
REQ-020 In RUN with md_op_dx=1 and no branch: md_start=1 for this cycle only; pc_en=fd_en=dx_en=0; xm_en=mw_en=1; xm_bubble=1; next state MD_WAIT.
REQ-021 In RUN with load_use_stall=1 only: pc_en=fd_en=0, dx_bubble=1, dx_en=xm_en=mw_en=1, next state RUN; the stall lasts exactly one cycle per assertion.
REQ-022 In RUN with no event: all enables=1, all flush/bubble outputs=0.
REQ-023 In MD_WAIT with md_ready=0: pc_en=fd_en=dx_en=0, xm_en=mw_en=1, xm_bubble=1, md_busy=1; wait counter increments.
REQ-024 In MD_WAIT with md_ready=1: all enables=1, xm_bubble=0, so the DX instruction advances with its result; next state RUN. md_exception is passed through by the datapath and does not change this behaviour.
REQ-025 When the wait counter reaches MD_TIMEOUT without md_ready, the block SHALL set md_timeout and behave as in REQ-024 in that cycle.
REQ-026 load_use_stall and branch_taken_dx SHALL be ignored in MD_WAIT.
REQ-027 md_start SHALL never be asserted in two consecutive cycles.
REQ-028 stall_count SHALL increment in every cycle with pc_en=0 and saturate at all-ones without wrap-around.
REQ-029 flush_count SHALL increment in every cycle with fd_flush=1 and saturate at all-ones without wrap-around.
REQ-030 The wait counter SHALL clear on every entry to MD_WAIT.

Reset
REQ-031 While reset=1, outputs SHALL be: all enables=0, fd_flush=dx_bubble=xm_bubble=1, md_start=0, md_busy=0.
REQ-032 On the first clock edge with reset=1: state<=RUN, counters<=0, md_timeout<=0, wait counter<=0.
REQ-033 Reset asserted during MD_WAIT SHALL abandon the operation without issuing a further md_start.

Structure
REQ-034 The state encoding (RUN=0, MD_WAIT=1) SHALL be defined in a shared include, pipeline_ctrl_defs.
REQ-035 One sub-module, sat_counter (parameterized width, inc and clr inputs), SHALL be instantiated twice, once for stall_count and once for flush_count.
REQ-036 All outputs SHALL be decoded combinationally from the registered state plus the current inputs.

Verification
REQ-037 load_use_stall=1 for 1 cycle in RUN -> pc_en=fd_en=0 and dx_bubble=1 for 1 cycle; stall_count=1.
REQ-038 branch_taken_dx=1 and load_use_stall=1 in the same cycle -> fd_flush=1, dx_bubble=1, pc_en=1; stall_count unchanged; flush_count=1.
REQ-039 md_op_dx=1, then md_ready on the 17th wait cycle -> md_start is a single pulse; md_busy high for 17 cycles; xm_bubble=0 and all enables=1 in the md_ready cycle.
REQ-040 md_op_dx=1 and md_ready never asserted -> md_timeout=1 after 63 wait cycles; state returns to RUN; md_timeout stays high until reset.
REQ-041 CNT_W=4 with 20 consecutive load-use stalls -> stall_count holds at 15.
REQ-042 reset asserted in the 5th cycle of MD_WAIT -> next cycle state=RUN, md_busy=0, counters=0, no md_start pulse.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// ============================================================================
//  Package : pipeline_ctrl_defs
//  Shared state encoding for the pipeline stall/flush controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_ctrl_defs;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } ctrlState_t;

    // Latch-control bundle: enables, nop injections, multdiv handshake.
    typedef struct packed {
        logic pcEn;
        logic fdEn;
        logic dxEn;
        logic xmEn;
        logic mwEn;
        logic fdFlush;
        logic dxBubble;
        logic xmBubble;
        logic mdStart;
        logic mdBusy;
    } ctrlOut_t;

    localparam ctrlOut_t c_CTRL_RUN = '{
        pcEn: 1'b1, fdEn: 1'b1, dxEn: 1'b1, xmEn: 1'b1, mwEn: 1'b1,
        fdFlush: 1'b0, dxBubble: 1'b0, xmBubble: 1'b0,
        mdStart: 1'b0, mdBusy: 1'b0
    };

    localparam ctrlOut_t c_CTRL_RESET = '{
        pcEn: 1'b0, fdEn: 1'b0, dxEn: 1'b0, xmEn: 1'b0, mwEn: 1'b0,
        fdFlush: 1'b1, dxBubble: 1'b1, xmBubble: 1'b1,
        mdStart: 1'b0, mdBusy: 1'b0
    };

endpackage : pipeline_ctrl_defs

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// ============================================================================
//  Module  : sat_counter
//  Up-counter that holds at all-ones instead of wrapping; clr has priority.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
//  Module  : pipeline_stall_ctrl
//  Stall/flush/bubble control for a 5-stage pipeline with a multicycle multdiv.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl
    import pipeline_ctrl_defs::*;
#(
    parameter int CNT_W      = 16,
    parameter int MD_TIMEOUT = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_use_stall,
    input  logic             branch_taken_dx,
    input  logic             md_op_dx,
    input  logic             md_ready,
    input  logic             md_exception,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                  c_WAIT_W     = $clog2(MD_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MD_TIMEOUT);

    ctrlState_t          r_state;
    ctrlState_t          w_stateNext;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic                r_mdTimeout;
    logic                w_timeoutHit;
    logic                w_release;
    ctrlOut_t            w_ctrl;
    logic                w_unusedExc;

    // Exceptions ride along with the result in the datapath; control ignores them.
    assign w_unusedExc = md_exception;

    assign w_timeoutHit = (r_state == ST_MD_WAIT) && !md_ready && (r_waitCnt == c_WAIT_LIMIT);
    assign w_release    = md_ready || w_timeoutHit;

    always_comb begin
        w_ctrl      = c_CTRL_RUN;
        w_stateNext = r_state;
        if (reset) begin
            w_ctrl      = c_CTRL_RESET;
            w_stateNext = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_dx) begin
                        w_ctrl.fdFlush  = 1'b1;
                        w_ctrl.dxBubble = 1'b1;
                    end else if (md_op_dx) begin
                        w_ctrl.mdStart  = 1'b1;
                        w_ctrl.pcEn     = 1'b0;
                        w_ctrl.fdEn     = 1'b0;
                        w_ctrl.dxEn     = 1'b0;
                        w_ctrl.xmBubble = 1'b1;
                        w_stateNext     = ST_MD_WAIT;
                    end else if (load_use_stall) begin
                        w_ctrl.pcEn     = 1'b0;
                        w_ctrl.fdEn     = 1'b0;
                        w_ctrl.dxBubble = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    w_ctrl.mdBusy = 1'b1;
                    if (w_release) begin
                        w_stateNext = ST_RUN;
                    end else begin
                        w_ctrl.pcEn     = 1'b0;
                        w_ctrl.fdEn     = 1'b0;
                        w_ctrl.dxEn     = 1'b0;
                        w_ctrl.xmBubble = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = ST_RUN;
                end
            endcase
        end
    end

    // Wait counter is held at zero throughout RUN so every MD_WAIT entry starts fresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_waitCnt   <= '0;
            r_mdTimeout <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == ST_RUN) begin
                r_waitCnt <= '0;
            end else if (!w_release) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (w_timeoutHit) begin
                r_mdTimeout <= 1'b1;
            end
        end
    end

    assign pc_en      = w_ctrl.pcEn;
    assign fd_en      = w_ctrl.fdEn;
    assign dx_en      = w_ctrl.dxEn;
    assign xm_en      = w_ctrl.xmEn;
    assign mw_en      = w_ctrl.mwEn;
    assign fd_flush   = w_ctrl.fdFlush;
    assign dx_bubble  = w_ctrl.dxBubble;
    assign xm_bubble  = w_ctrl.xmBubble;
    assign md_start   = w_ctrl.mdStart;
    assign md_busy    = w_ctrl.mdBusy;
    assign md_timeout = r_mdTimeout | (w_timeoutHit & ~reset);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stallCnt (
        .clk   (clock),
        .clr   (reset),
        .inc   (~w_ctrl.pcEn),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flushCnt (
        .clk   (clock),
        .clr   (reset),
        .inc   (w_ctrl.fdFlush),
        .count (flush_count)
    );

endmodule : pipeline_stall_ctrl

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
//  Module  : tb_pipeline_stall_ctrl
//  Directed self-checking bench for pipeline_stall_ctrl (default and CNT_W=4).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

    logic clock;
    logic reset;
    logic load_use_stall, branch_taken_dx, md_op_dx, md_ready, md_exception;

    logic pc_en, fd_en, dx_en, xm_en, mw_en;
    logic fd_flush, dx_bubble, xm_bubble, md_start, md_busy, md_timeout;
    logic [15:0] stall_count, flush_count;

    logic unused4_pc, unused4_fd, unused4_dx, unused4_xm, unused4_mw;
    logic unused4_ff, unused4_db, unused4_xb, unused4_st, unused4_bz, unused4_to;
    logic [3:0] stall_count4;
    logic [3:0] unused4_flush;

    int checks = 0;
    int errors = 0;
    int busyCount;
    int startCount;
    int badCycles;
    int consecStart = 0;
    logic prevStart = 1'b0;

    // Order: pc fd dx xm mw | fdFlush dxBubble xmBubble | mdStart mdBusy
    localparam logic [9:0] C_RESET   = 10'b00000_111_00;
    localparam logic [9:0] C_RUN     = 10'b11111_000_00;
    localparam logic [9:0] C_BRANCH  = 10'b11111_110_00;
    localparam logic [9:0] C_LUSTALL = 10'b00111_010_00;
    localparam logic [9:0] C_MDSTART = 10'b00011_001_10;
    localparam logic [9:0] C_MDWAIT  = 10'b00011_001_01;
    localparam logic [9:0] C_MDREL   = 10'b11111_000_01;

    logic [9:0] ctl;
    assign ctl = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble, md_start, md_busy};

    pipeline_stall_ctrl dut (
        .clock(clock), .reset(reset),
        .load_use_stall(load_use_stall), .branch_taken_dx(branch_taken_dx),
        .md_op_dx(md_op_dx), .md_ready(md_ready), .md_exception(md_exception),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
        .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_stall_ctrl #(.CNT_W(4), .MD_TIMEOUT(63)) dut4 (
        .clock(clock), .reset(reset),
        .load_use_stall(load_use_stall), .branch_taken_dx(branch_taken_dx),
        .md_op_dx(md_op_dx), .md_ready(md_ready), .md_exception(md_exception),
        .pc_en(unused4_pc), .fd_en(unused4_fd), .dx_en(unused4_dx), .xm_en(unused4_xm), .mw_en(unused4_mw),
        .fd_flush(unused4_ff), .dx_bubble(unused4_db), .xm_bubble(unused4_xb),
        .md_start(unused4_st), .md_busy(unused4_bz), .md_timeout(unused4_to),
        .stall_count(stall_count4), .flush_count(unused4_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (md_start && prevStart) consecStart = consecStart + 1;
        prevStart = md_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic l, input logic b, input logic m,
                         input logic r, input logic e);
        @(posedge clock);
        #1;
        reset = rst; load_use_stall = l; branch_taken_dx = b;
        md_op_dx = m; md_ready = r; md_exception = e;
        #2;
    endtask

    initial begin
        reset = 1'b1; load_use_stall = 1'b0; branch_taken_dx = 1'b0;
        md_op_dx = 1'b0; md_ready = 1'b0; md_exception = 1'b0;

        // Reset behaviour
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 1, 0, 0);
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        apply(0, 0, 0, 0, 0, 0);
        chk("post_reset_ctl", 32'(ctl), 32'(C_RUN));
        chk("post_reset_stall", 32'(stall_count), 32'd0);
        chk("post_reset_flush", 32'(flush_count), 32'd0);
        chk("post_reset_timeout", 32'(md_timeout), 32'd0);

        // Single load-use stall
        apply(0, 1, 0, 0, 0, 0);
        chk("lus_ctl", 32'(ctl), 32'(C_LUSTALL));
        apply(0, 0, 0, 0, 0, 0);
        chk("lus_after_ctl", 32'(ctl), 32'(C_RUN));
        chk("lus_stall_cnt", 32'(stall_count), 32'd1);

        // Branch wins over load-use
        apply(0, 1, 1, 0, 0, 0);
        chk("branch_ctl", 32'(ctl), 32'(C_BRANCH));
        apply(0, 0, 0, 0, 0, 0);
        chk("branch_stall_cnt", 32'(stall_count), 32'd1);
        chk("branch_flush_cnt", 32'(flush_count), 32'd1);

        // Multdiv with md_ready on 17th wait cycle; hazards injected mid-wait
        busyCount = 0; startCount = 0; badCycles = 0;
        apply(0, 0, 0, 1, 0, 0);
        chk("md_start_ctl", 32'(ctl), 32'(C_MDSTART));
        busyCount += int'(md_busy); startCount += int'(md_start);
        for (int k = 1; k <= 16; k++) begin
            apply(0, (k == 3), (k == 3), 1, 0, 0);
            if (ctl !== C_MDWAIT) badCycles++;
            busyCount += int'(md_busy); startCount += int'(md_start);
        end
        chk("md_wait_cycles", 32'(badCycles), 32'd0);
        apply(0, 0, 0, 1, 1, 1);
        chk("md_ready_ctl", 32'(ctl), 32'(C_MDREL));
        busyCount += int'(md_busy); startCount += int'(md_start);
        apply(0, 0, 0, 0, 0, 0);
        chk("md_back_run", 32'(ctl), 32'(C_RUN));
        chk("md_busy_len", 32'(busyCount), 32'd17);
        chk("md_start_pulses", 32'(startCount), 32'd1);
        chk("md_stall_cnt", 32'(stall_count), 32'd18);
        chk("md_no_timeout", 32'(md_timeout), 32'd0);

        // Timeout: 63 plain wait cycles, forced release on the next one
        badCycles = 0;
        apply(0, 0, 0, 1, 0, 0);
        chk("to_start_ctl", 32'(ctl), 32'(C_MDSTART));
        for (int k = 1; k <= 63; k++) begin
            apply(0, 0, 0, 1, 0, 0);
            if (ctl !== C_MDWAIT || md_timeout !== 1'b0) badCycles++;
        end
        chk("to_wait_cycles", 32'(badCycles), 32'd0);
        apply(0, 0, 0, 1, 0, 0);
        chk("to_release_ctl", 32'(ctl), 32'(C_MDREL));
        chk("to_flag_set", 32'(md_timeout), 32'd1);
        apply(0, 0, 0, 0, 0, 0);
        chk("to_back_run", 32'(ctl), 32'(C_RUN));
        apply(0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("to_sticky", 32'(md_timeout), 32'd1);
        chk("to_stall_cnt", 32'(stall_count), 32'd83);

        // Reset in the 5th MD_WAIT cycle
        apply(0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) apply(0, 0, 0, 1, 0, 0);
        chk("rst_md_busy_before", 32'(md_busy), 32'd1);
        apply(1, 0, 0, 1, 0, 0);
        chk("rst_md_ctl", 32'(ctl), 32'(C_RESET));
        apply(0, 0, 0, 0, 0, 0);
        chk("rst_md_after_ctl", 32'(ctl), 32'(C_RUN));
        chk("rst_md_stall", 32'(stall_count), 32'd0);
        chk("rst_md_flush", 32'(flush_count), 32'd0);
        chk("rst_md_timeout", 32'(md_timeout), 32'd0);

        // 20 consecutive load-use stalls: 4-bit counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            apply(0, 1, 0, 0, 0, 0);
            if (k == 16) chk("sat4_at_15", 32'(stall_count4), 32'd15);
        end
        apply(0, 0, 0, 0, 0, 0);
        chk("sat4_hold", 32'(stall_count4), 32'd15);
        chk("sat16_count", 32'(stall_count), 32'd20);

        chk("md_start_consecutive", 32'(consecStart), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_stall_ctrl

`default_nettype wire
